// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and a helper that classifies M-extension operations.
package alu_pkg;

  // Base ops keep the original 4-bit encodings, zero-extended to 5 bits.
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_LUI    = 5'h02;
  localparam logic [4:0] ALU_AND    = 5'h03;
  localparam logic [4:0] ALU_XOR    = 5'h04;
  localparam logic [4:0] ALU_OR     = 5'h05;
  localparam logic [4:0] ALU_SLL    = 5'h06;
  localparam logic [4:0] ALU_SRL    = 5'h07;
  localparam logic [4:0] ALU_SRA    = 5'h08;
  localparam logic [4:0] ALU_SLT    = 5'h09;
  localparam logic [4:0] ALU_SLTU   = 5'h0A;

  // M-extension ops occupy 1_0xxx; the low three bits select the op.
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_mext(input logic [4:0] code);
    return (code[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake/operand bundle between the EX stage and the sequential ALU.
//   master: drives in_valid, ALUCode, A, B, flush; sees in_ready, out_valid, out_result
//   slave : the ALU side of the same signals
interface alu_seq_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ALUCode;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, ALUCode, A, B, flush,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, ALUCode, A, B, flush,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide core.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operands and begin XLEN iterations
//   abort      : cancel any run in progress (takes priority over start)
//   op_div     : 1 = divide a by b, 0 = multiply a by b
//   a, b       : unsigned operands
//   done       : one-cycle pulse the cycle after the last iteration
//   product    : 2*XLEN-bit product (valid with done, multiply mode)
//   quotient   : quotient (valid with done, divide mode)
//   remainder  : remainder (valid with done, divide mode)
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              op_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  localparam int unsigned CW = $clog2(XLEN);

  logic              run;
  logic              fin;
  logic              div_mode;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   qreg;
  logic [XLEN-1:0]   opb;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              fits;
  logic [2*XLEN-1:0] acc_mul;
  logic [2*XLEN-1:0] acc_div;
  logic [XLEN-1:0]   q_div;

  always_comb begin
    // Multiply: {upper, multiplier} shifts right, adding the multiplicand
    // into the upper half whenever the current multiplier LSB is set.
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    acc_mul = {add_sum, acc[XLEN-1:1]};

    // Divide: partial remainder lives in acc[XLEN-1:0], dividend bits are
    // shifted out of qreg while quotient bits are shifted in.
    shifted = {acc[XLEN-1:0], qreg[XLEN-1]};
    fits    = (shifted >= {1'b0, opb});
    diff    = shifted - {1'b0, opb};
    if (fits) begin
      acc_div = {{XLEN{1'b0}}, diff[XLEN-1:0]};
      q_div   = {qreg[XLEN-2:0], 1'b1};
    end else begin
      acc_div = {{XLEN{1'b0}}, shifted[XLEN-1:0]};
      q_div   = {qreg[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= 1'b0;
      fin      <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      qreg     <= '0;
      opb      <= '0;
    end else begin
      fin <= 1'b0;
      if (abort) begin
        run <= 1'b0;
        cnt <= '0;
      end else if (start) begin
        run      <= 1'b1;
        cnt      <= '0;
        div_mode <= op_div;
        opb      <= b;
        if (op_div) begin
          acc  <= '0;
          qreg <= a;
        end else begin
          acc  <= {{XLEN{1'b0}}, a};
          qreg <= '0;
        end
      end else if (run) begin
        if (div_mode) begin
          acc  <= acc_div;
          qreg <= q_div;
        end else begin
          acc  <= acc_mul;
        end
        cnt <= cnt + CW'(1);
        if (cnt == CW'(XLEN - 1)) begin
          run <= 1'b0;
          fin <= 1'b1;
        end
      end
    end
  end

  assign done      = fin;
  assign product   = acc;
  assign quotient  = qreg;
  assign remainder = acc[XLEN-1:0];

endmodule

// File: rtl/alu_seq.sv
// Pipelined EX-stage ALU: single-cycle RV32I ops and fixed-latency
// (XLEN+1) RV32M ops on a shared iterative datapath.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of alu_seq_if (valid/ready request, flush,
//           out_valid pulse with registered out_result)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  state_t state, state_nxt;

  logic              accept;
  logic              core_start;
  logic              core_done;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  logic [XLEN-1:0]   base_res;
  logic [SHW-1:0]    shamt;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [2:0]        m_op;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic [XLEN-1:0]   a_hold;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;
  logic [XLEN-1:0]   final_res;

  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mext(bus.ALUCode)) state_nxt = BUSY;
      BUSY: if (bus.flush || core_done)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready = (state == IDLE);
    accept       = bus.in_valid && (state == IDLE) && !bus.flush;
    core_start   = accept && is_mext(bus.ALUCode);
  end

  // ---------------- Base (single-cycle) ops ----------------
  assign shamt = bus.B[SHW-1:0];

  always_comb begin
    unique case (bus.ALUCode)
      ALU_ADD:  base_res = bus.A + bus.B;
      ALU_SUB:  base_res = bus.A - bus.B;
      ALU_LUI:  base_res = bus.B;
      ALU_AND:  base_res = bus.A & bus.B;
      ALU_XOR:  base_res = bus.A ^ bus.B;
      ALU_OR:   base_res = bus.A | bus.B;
      ALU_SLL:  base_res = bus.A << shamt;
      ALU_SRL:  base_res = bus.A >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(bus.A) >>> shamt);
      ALU_SLT:  base_res = XLEN'($signed(bus.A) < $signed(bus.B));
      ALU_SLTU: base_res = XLEN'(bus.A < bus.B);
      default:  base_res = '0;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  // The core is unsigned; signed ops feed magnitudes and the signs are
  // re-applied to the raw result on completion.
  always_comb begin
    a_signed = (bus.ALUCode == ALU_MULH) || (bus.ALUCode == ALU_MULHSU) ||
               (bus.ALUCode == ALU_DIV)  || (bus.ALUCode == ALU_REM);
    b_signed = (bus.ALUCode == ALU_MULH) ||
               (bus.ALUCode == ALU_DIV)  || (bus.ALUCode == ALU_REM);
    a_neg    = a_signed && bus.A[XLEN-1];
    b_neg    = b_signed && bus.B[XLEN-1];
    mag_a    = a_neg ? ('0 - bus.A) : bus.A;
    mag_b    = b_neg ? ('0 - bus.B) : bus.B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_op     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_hold   <= '0;
    end else if (core_start) begin
      m_op     <= bus.ALUCode[2:0];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (bus.B == '0);
      a_hold   <= bus.A;
    end
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .abort     (bus.flush),
    .op_div    (bus.ALUCode[2]),
    .a         (mag_a),
    .b         (mag_b),
    .done      (core_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // ---------------- M-op sign correction / special cases ----------------
  // Overflow (most-negative / -1) needs no special path: the magnitude
  // divide yields 2^(XLEN-1) with remainder 0, which is the required answer.
  always_comb begin
    prod_s = neg_res ? ('0 - product)   : product;
    quot_s = neg_res ? ('0 - quotient)  : quotient;
    rem_s  = neg_rem ? ('0 - remainder) : remainder;
    unique case (m_op)
      3'd0:       final_res = product[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       final_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: final_res = div_zero ? '1 : quot_s;
      default:    final_res = div_zero ? a_hold : rem_s;
    endcase
  end

  // ---------------- Result register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept && !is_mext(bus.ALUCode)) begin
        out_valid_q <= 1'b1;
        result_q    <= base_res;
      end else if ((state == BUSY) && core_done && !bus.flush) begin
        out_valid_q <= 1'b1;
        result_q    <= final_res;
      end
    end
  end

  // A base result registered the edge before a flush is withheld while
  // flush is high.
  assign bus.out_valid  = out_valid_q && !bus.flush;
  assign bus.out_result = result_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, pipelined successor to the core's combinational ALU: registered result, valid/ready handshake, adds RV32M multiply/divide/remainder.
- Base RV32I ops complete in 1 cycle; M-extension ops use a shared iterative shift-add/restoring-divide datapath with fixed latency.
- Sits in the EX stage; the hazard unit stalls on in_ready=0 and the pipeline kills in-flight ops with flush.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥8.
- SHW, $clog2(XLEN), shift-amount bits taken from B.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept this cycle
- ALUCode  input  5  operation select (codes below)
- A  input  XLEN  operand 1
- B  input  XLEN  operand 2
- flush  input  1  abort any in-flight op; discard offered op
- out_valid  output  1  one-cycle pulse: out_result is new
- out_result  output  XLEN  registered result, held until next completion

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0, all datapath registers cleared; reset mid-operation abandons the op, and no out_valid follows.
- Accept = in_valid & in_ready & ~flush at a rising edge (edge 0).
- Codes 0_0000..0_1010: add, sub, lui(pass B), and, xor, or, sll, srl, sra, slt, sltu.
  - Shift amount = B[SHW-1:0]; upper B bits ignored.
  - slt/sltu yield 0 or 1, zero-extended.
  - Arithmetic is modulo 2^XLEN.
- Codes 1_0000..1_0111: mul, mulh, mulhsu, mulhu, div, divu, rem, remu (RISC-V M semantics).
- Undefined codes: result 0, base-op timing.
- Base op: out_valid=1 in the cycle after edge 0 (latency 1). in_ready stays 1, so back-to-back issue is allowed: one result per cycle.
- M op, FSM IDLE -> BUSY -> IDLE:
  - Edge 0: latch operand magnitudes and sign flags; counter=0; state=BUSY; in_ready=0.
  - BUSY: one iteration per cycle for XLEN cycles (counter 0..XLEN-1).
  - Edge XLEN+1: sign-correct and write out_result; out_valid=1 and state=IDLE in that cycle; in_ready=1 in the same cycle.
  - Latency is exactly XLEN+1 for every M op, special cases included.
- mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits of the 2*XLEN product.
- Divide by zero: div/divu quotient = all ones; rem/remu = A.
- Signed overflow (A = most-negative, B = -1): div = A; rem = 0.
- Signed div truncates toward zero; remainder takes the dividend's sign.
- Flush:
  - When asserted, no accept that cycle.
  - Any BUSY op is aborted: state=IDLE at the next edge, no out_valid.
  - A pending base-op out_valid for an op accepted the edge before is suppressed (out_valid forced 0 while flush=1).
  - out_result keeps its old value.
- Simultaneous flush and BUSY-completion edge: flush wins; no out_valid.
- in_valid while in_ready=0 is ignored; the producer must hold the op.

Decomposition:
- Package alu_pkg:
  - ALUCode localparams (existing 4-bit values zero-extended, plus the 8 M codes).
  - FSM state encoding IDLE/BUSY.
  - Helper function is_mext(code).
- One sub-module, muldiv_iter:
  - Parametrised by XLEN.
  - Iterative unsigned core with start/done.
  - Holds the counter, the 2*XLEN accumulator/remainder register and the quotient shift register.
- Sign handling and special-case selection stay in alu_seq.

Test Plan:
- Base ops back-to-back, XLEN=32: add 0x7FFFFFFF+1, then sltu 1,0xFFFFFFFF, then sra 0x80000000 by B=0x21 -> out_valid on 3 consecutive cycles, results 0x80000000, 1, 0xC0000000 (shift uses 1).
- mulh 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; mulhu same operands -> 0xFFFFFFFE; each out_valid exactly 33 cycles after accept, in_ready=0 for cycles 1..32.
- div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem same operands -> 0; divu 7/0 -> 0xFFFFFFFF; remu 7/0 -> 7; div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF.
- Flush at cycle 10 of a div -> no out_valid, in_ready=1 next cycle, out_result unchanged. A new add 2+3 then yields 5 after 1 cycle.
- Reset asserted asynchronously mid-mul (between edges) -> out_valid, out_result and counter go to 0 immediately, in_ready=1; after release, mul 3×5 -> 15 at latency 33.
- XLEN=16 build: mulhu 0xFFFF×0xFFFF -> 0xFFFE at latency 17; sll by B=0x0011 -> shift 1.
